dac_frame_tx: RTL and testbench

DAC_FRAME_TX -- requirements
Module: dac_frame_tx

---
 rtl/dac_frame_tx.sv | 187 ++++++++++++++++++
 tb/tb_dac_frame_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_tx.sv
// Frame FIFO feeding a mode-0 SPI serialiser for a multi-channel audio DAC.
// Optional DAC_OFFSET_BINARY_EN flips each channel MSB at load time.
`timescale 1ns/1ps
module dac_frame_tx #(
   parameter int clock_max  = 25_000_000,
   parameter int SAMPLE_W   = 16,
   parameter int N_CH       = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int SCLK_DIV   = 4
) (
   input  logic                     clk_25mhz,
   input  logic                     reset,
   input  logic                     data_ready,
   input  logic [N_CH*SAMPLE_W-1:0] audio_in,
   output logic                     fifo_full,
   output logic                     overflow,
   output logic                     sclk_out,
   output logic                     mosi_out,
   output logic                     active_out
);

   localparam int FB = N_CH * SAMPLE_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(2 * SCLK_DIV + 1);
   localparam int BW = $clog2(FB + 1);

   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST = DW'(2 * SCLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);

   // Illegal parameter sets disable writes so the block stays inert.
   localparam bit CFG_OK = (clock_max > 0) && (SCLK_DIV >= 1)
                           && (FIFO_DEPTH >= 2)
                           && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [FB-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [1:0]      state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [FB-1:0]   shreg_q, shreg_d;
   logic            overflow_q, overflow_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            active_q, active_d;

   logic            full;
   logic            push;
   logic            pop;
   logic [FB-1:0]   head;
   logic [FB-1:0]   load_word;

   assign full = (count_q == FULL_CNT);
   assign push = CFG_OK && data_ready && !full;
   assign pop  = (state_q == S_LOAD);
   assign head = mem_q[rd_ptr_q];

`ifdef DAC_OFFSET_BINARY_EN
   logic [FB-1:0] ob_mask;

   always_comb begin
      ob_mask = '0;
      for (int c = 0; c < N_CH; c++) begin
         ob_mask[c*SAMPLE_W + SAMPLE_W - 1] = 1'b1;
      end
   end

   assign load_word = head ^ ob_mask;
`else
   assign load_word = head;
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = data_ready && full;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      active_d = active_q;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) state_d = S_LOAD;
         end
         S_LOAD: begin
            shreg_d  = load_word;
            mosi_d   = load_word[FB-1];
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            state_d  = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = !sclk_q;
               // Data only moves on the falling edge: mode 0.
               if (sclk_q) begin
                  shreg_d = shreg_q << 1;
                  mosi_d  = shreg_q[FB-2];
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     mosi_d   = 1'b0;
                     active_d = 1'b0;
                     state_d  = S_GAP;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
            active_d = 1'b0;
            if (div_q == GAP_LAST) begin
               div_d   = '0;
               state_d = S_IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_25mhz) begin
      if (push) mem_q[wr_ptr_q] <= audio_in;
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         overflow_q <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         overflow_q <= overflow_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         active_q   <= active_d;
      end
   end

   assign fifo_full  = full;
   assign overflow   = overflow_q;
   assign sclk_out   = sclk_q;
   assign mosi_out   = mosi_q;
   assign active_out = active_q;

endmodule

// File: tb/tb_dac_frame_tx.sv
// Scoreboard bench for dac_frame_tx: frames captured on SCLK rising edges.
// Expected frames are queued at the strobe and popped at each frame end.
`timescale 1ns/1ps
module tb_dac_frame_tx;

   localparam int SW = 16;
   localparam int NC = 2;
   localparam int FD = 8;
   localparam int SD = 2;
   localparam int FB = SW * NC;

   logic          clk = 1'b0;
   logic          reset;
   logic          data_ready;
   logic [FB-1:0] audio_in;
   logic          fifo_full;
   logic          overflow;
   logic          sclk_out;
   logic          mosi_out;
   logic          active_out;

   int checks = 0;
   int errors = 0;
   logic [FB-1:0] exp_q [$];

   dac_frame_tx #(
      .SAMPLE_W(SW), .N_CH(NC), .FIFO_DEPTH(FD), .SCLK_DIV(SD)
   ) dut (
      .clk_25mhz (clk),
      .reset     (reset),
      .data_ready(data_ready),
      .audio_in  (audio_in),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .sclk_out  (sclk_out),
      .mosi_out  (mosi_out),
      .active_out(active_out)
   );

   always #20 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FB-1:0] model(input logic [FB-1:0] w);
      logic [FB-1:0] m;
      m = 32'h8000_8000;
`ifdef DAC_OFFSET_BINARY_EN
      return w ^ m;
`else
      return w ^ (m & 32'h0);
`endif
   endfunction

   // Monitor: rebuilds each frame from mosi at SCLK rising edges.
   int            bits = 0;
   int            hi_cnt = 0;
   int            low_cnt = 0;
   int            last_gap = 0;
   int            clr_req = 0;
   int            clr_seen = 0;
   logic          prev_sclk = 1'b0;
   logic          prev_act = 1'b0;
   logic [FB-1:0] shift_in = '0;

   always @(negedge clk) begin
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         bits     = 0;
         hi_cnt   = 0;
         low_cnt  = 0;
         shift_in = '0;
      end else begin
         if (sclk_out && !prev_sclk) begin
            shift_in = {shift_in[FB-2:0], mosi_out};
            bits++;
         end
         if (active_out) hi_cnt++;
         if (active_out && !prev_act) last_gap = low_cnt;
         if (!active_out && prev_act) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_size", exp_q.size(), 1);
            end else begin
               check_eq("frame", shift_in, exp_q.pop_front());
               check_eq("sclk_pulses", bits, FB);
               check_eq("active_cycles", hi_cnt, 2 * SD * FB);
            end
            bits    = 0;
            hi_cnt  = 0;
            low_cnt = 1;
         end else if (!active_out) begin
            low_cnt++;
         end
      end
      prev_sclk = sclk_out;
      prev_act  = active_out;
   end

   task automatic strobe(input logic [FB-1:0] w, input bit expect_store);
      data_ready = 1'b1;
      audio_in   = w;
      if (expect_store) exp_q.push_back(model(w));
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || active_out) && n < max) begin
         @(negedge clk);
         n++;
      end
      check_eq({"drain_", tag}, exp_q.size(), 0);
      repeat (2 * SD + 4) @(negedge clk);
   endtask

   task automatic wait_active(input string tag);
      int n = 0;
      while (!active_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq({"start_", tag}, active_out, 1);
   endtask

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int n;
      reset      = 1'b1;
      data_ready = 1'b1;
      audio_in   = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      check_eq("rst_full", fifo_full, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_sclk", sclk_out, 0);
      check_eq("rst_mosi", mosi_out, 0);
      check_eq("rst_act", active_out, 0);
      reset      = 1'b0;
      data_ready = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("rst_strobe_act", active_out, 0);
      check_eq("rst_strobe_full", fifo_full, 0);

      // Single frame and latency.
      strobe(32'hA5A5_0F0F, 1'b1);
      check_eq("lat_e0", active_out, 0);
      @(negedge clk);
      check_eq("lat_e1", active_out, 0);
      @(negedge clk);
      check_eq("lat_e2", active_out, 1);
      wait_drain("single", 400);

      // Overflow while busy shifting.
      strobe(32'h1111_0000, 1'b1);
      wait_active("ovf");
      for (int i = 0; i < 9; i++) begin
         data_ready = 1'b1;
         audio_in   = 32'h2000_0000 + i;
         if (i < 8) exp_q.push_back(model(audio_in));
         @(negedge clk);
         check_eq($sformatf("full_w%0d", i), fifo_full, (i >= 7));
         check_eq($sformatf("ovf_w%0d", i), overflow, (i == 8));
      end
      data_ready = 1'b0;
      @(negedge clk);
      check_eq("ovf_one_cycle", overflow, 0);
      wait_drain("ovf", 3000);

      // Back-to-back frames.
      strobe(32'h0001_0002, 1'b1);
      strobe(32'h8000_7FFF, 1'b1);
      wait_drain("b2b", 800);
      check_eq("b2b_gap", last_gap, 2 * SD + 2);

      // Reset mid-frame with three frames queued.
      strobe(32'h3333_3333, 1'b0);
      strobe(32'h4444_4444, 1'b0);
      strobe(32'h5555_5555, 1'b0);
      strobe(32'h6666_6666, 1'b0);
      n = 0;
      while (bits < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("mid_bit10", bits, 10);
      reset = 1'b1;
      @(posedge clk);
      #1;
      clr_req++;
      reset = 1'b0;
      @(negedge clk);
      check_eq("mid_sclk", sclk_out, 0);
      check_eq("mid_act", active_out, 0);
      check_eq("mid_full", fifo_full, 0);
      check_eq("mid_mosi", mosi_out, 0);
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk);
         seen = seen | sclk_out | active_out;
      end
      check_eq("mid_quiet", seen, 0);

      // Pop and push in the same cycle while full.
      strobe(32'h7777_0001, 1'b1);
      wait_active("bnd");
      for (int i = 0; i < 8; i++) strobe(32'h9000_0000 + i, 1'b1);
      check_eq("bnd_full", fifo_full, 1);
      n = 0;
      while (active_out && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("bnd_fall", active_out, 0);
      repeat (5) @(negedge clk);
      strobe(32'hBAD0_0000, 1'b0);
      check_eq("bnd_ovf", overflow, 1);
      check_eq("bnd_not_full", fifo_full, 0);
      check_eq("bnd_load", active_out, 1);
      strobe(32'hC000_0001, 1'b1);
      check_eq("bnd_refill", fifo_full, 1);
      check_eq("bnd_no_ovf", overflow, 0);
      strobe(32'hBAD1_0000, 1'b0);
      check_eq("bnd_ovf2", overflow, 1);
      wait_drain("bnd", 3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
